// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_t;

  function automatic int id_w(input int num_req);
    return (num_req > 32'sd1) ? $clog2(num_req) : 32'sd1;
  endfunction

  function automatic int cnt_w(input int burst_len);
    return $clog2(burst_len + 32'sd1);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO-side bundle of the write arbiter; master is the arbiter's view.
interface fifo_wr_arbiter_if #(
  parameter int SIZE    = 8,
  parameter int NUM_REQ = 4
);
  import fifo_arb_pkg::*;

  localparam int ID_W = id_w(NUM_REQ);

  logic [NUM_REQ-1:0]      req;
  logic [NUM_REQ*SIZE-1:0] req_data;
  logic [NUM_REQ-1:0]      ack;
  logic                    f_flag;
  logic                    almost_full_flag;
  logic                    valid_write;
  logic [SIZE-1:0]         wr_data;
  logic [ID_W-1:0]         grant_id;
  logic                    busy;

  modport master (
    input  req, req_data, f_flag, almost_full_flag,
    output ack, valid_write, wr_data, grant_id, busy
  );

  modport slave (
    output req, req_data, f_flag, almost_full_flag,
    input  ack, valid_write, wr_data, grant_id, busy
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin search: first requester strictly after last_owner, with wrap.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_owner,
  output logic               found,
  output logic [ID_W-1:0]    idx
);

  int dist_s;
  int best_s;

  // Nearest requesting index, measured as rotational distance past last_owner.
  always_comb begin
    found  = 1'b0;
    idx    = '0;
    dist_s = 32'sd0;
    best_s = NUM_REQ;
    for (int i = 0; i < NUM_REQ; i++) begin
      dist_s = (i + NUM_REQ - int'(last_owner) - 32'sd1) % NUM_REQ;
      if (req[i] && (dist_s < best_s)) begin
        best_s = dist_s;
        idx    = ID_W'(i);
        found  = 1'b1;
      end else begin
        best_s = best_s;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for the async FIFO write port.
// Optional: define FIFO_ARB_AF_THROTTLE_EN to hold off new grants while almost_full_flag is high.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int SIZE      = 8,
  parameter int NUM_REQ   = 4,
  parameter int BURST_LEN = 4
) (
  input  logic               clk,
  input  logic               n_rst,
  fifo_wr_arbiter_if.master  bus
);

  localparam int ID_W  = id_w(NUM_REQ);
  localparam int CNT_W = cnt_w(BURST_LEN);
  localparam logic [CNT_W-1:0]   LAST_BEAT = CNT_W'(BURST_LEN - 1);
  localparam logic [ID_W-1:0]    LAST_RST  = ID_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0  = {{(NUM_REQ-1){1'b0}}, 1'b1};

  arb_state_t       state_q, state_d;
  logic [ID_W-1:0]  owner_q, owner_d;
  logic [ID_W-1:0]  last_owner_q, last_owner_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic             pick_found_s;
  logic [ID_W-1:0]  pick_idx_s;
  logic             grant_ok_s;
  logic             owner_req_s;
  logic             accept_s;
  logic [SIZE-1:0]  owner_data_s;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req        (bus.req),
    .last_owner (last_owner_q),
    .found      (pick_found_s),
    .idx        (pick_idx_s)
  );

`ifdef FIFO_ARB_AF_THROTTLE_EN
  assign grant_ok_s = pick_found_s & ~bus.f_flag & ~bus.almost_full_flag;
`else
  logic unused_af_s;
  assign unused_af_s = bus.almost_full_flag;
  assign grant_ok_s  = pick_found_s & ~bus.f_flag;
`endif

  // f_flag gates the strobe combinationally so a full FIFO is never written.
  assign owner_req_s  = bus.req[owner_q];
  assign accept_s     = (state_q == ARB_BURST) & owner_req_s & ~bus.f_flag;
  assign owner_data_s = bus.req_data[int'(owner_q)*SIZE +: SIZE];

  assign bus.valid_write = accept_s;
  assign bus.ack         = accept_s ? (ONE_HOT0 << owner_q) : '0;
  assign bus.wr_data     = (state_q == ARB_BURST) ? owner_data_s : '0;
  assign bus.grant_id    = owner_q;
  assign bus.busy        = (state_q == ARB_BURST);

  // Arbitration and burst sequencing.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (grant_ok_s) begin
          owner_d    = pick_idx_s;
          beat_cnt_d = '0;
          state_d    = ARB_BURST;
        end else begin
          state_d    = ARB_IDLE;
        end
      end
      ARB_BURST: begin
        if (accept_s) begin
          beat_cnt_d = beat_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          beat_cnt_d = beat_cnt_q;
        end
        if (!owner_req_s || (accept_s && (beat_cnt_q == LAST_BEAT))) begin
          state_d      = ARB_IDLE;
          last_owner_d = owner_q;
        end else begin
          state_d      = ARB_BURST;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State registers; last_owner resets so requester 0 wins first.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= ARB_IDLE;
      owner_q      <= '0;
      last_owner_q <= LAST_RST;
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: expected writes queued at stimulus time.
module tb_fifo_wr_arbiter;

  localparam int SIZE      = 8;
  localparam int NUM_REQ   = 4;
  localparam int BURST_LEN = 4;

  typedef struct {
    int              id;
    logic [SIZE-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic n_rst;

  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.SIZE(SIZE), .NUM_REQ(NUM_REQ)) bus ();

  fifo_wr_arbiter #(
    .SIZE      (SIZE),
    .NUM_REQ   (NUM_REQ),
    .BURST_LEN (BURST_LEN)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_writes = 0;
  int   prod_cnt[NUM_REQ];
  int   exp_cnt[NUM_REQ];
  int   used;
  int   base;

  logic               s_vw;
  logic               s_busy;
  logic [NUM_REQ-1:0] s_ack;
  logic [1:0]         s_gid;
  logic [SIZE-1:0]    s_wd;

  function automatic logic [SIZE-1:0] data_of(input int id, input int k);
    return SIZE'(((id + 1) << 4) | (k & 15));
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_burst(input int id, input int n);
    for (int k = 0; k < n; k++) begin
      sb.push_back('{id: id, data: data_of(id, exp_cnt[id])});
      exp_cnt[id]++;
    end
  endtask

  task automatic drive_data();
    for (int i = 0; i < NUM_REQ; i++)
      bus.req_data[i*SIZE +: SIZE] = data_of(i, prod_cnt[i]);
  endtask

  // One clock: sample at negedge, score any write, advance producers after posedge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    s_vw   = bus.valid_write;
    s_ack  = bus.ack;
    s_busy = bus.busy;
    s_gid  = bus.grant_id;
    s_wd   = bus.wr_data;
    if (s_vw) begin
      n_writes++;
      if (sb.size() == 0) begin
        check_eq("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check_eq("wr_owner", 32'(s_gid), 32'(e.id));
        check_eq("wr_data", 32'(s_wd), 32'(e.data));
        check_eq("wr_ack", 32'(s_ack), 32'd1 << e.id);
      end
    end else begin
      check_eq("ack_no_write", 32'(s_ack), 32'd0);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++)
      if (s_ack[i]) prod_cnt[i]++;
    drive_data();
  endtask

  task automatic run_until(input int target, input int budget, output int cycles);
    cycles = 0;
    while ((n_writes < target) && (cycles < budget)) begin
      tick();
      cycles++;
    end
    if (n_writes < target) check_eq("timeout_writes", 32'(n_writes), 32'(target));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NUM_REQ; i++) begin
      prod_cnt[i] = 0;
      exp_cnt[i]  = 0;
    end
    n_rst                = 1'b0;
    bus.req              = 4'b1111;
    bus.f_flag           = 1'b0;
    bus.almost_full_flag = 1'b0;
    drive_data();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ack", 32'(bus.ack), 32'd0);
    check_eq("rst_vw", 32'(bus.valid_write), 32'd0);
    check_eq("rst_wr_data", 32'(bus.wr_data), 32'd0);
    check_eq("rst_gid", 32'(bus.grant_id), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    bus.req = 4'b0000;
    n_rst   = 1'b1;
    @(posedge clk);
    #1;

    // All requesting: grants 0,1,2,3,0 with one arbitration cycle per burst.
    base = n_writes;
    push_burst(0, 4); push_burst(1, 4); push_burst(2, 4); push_burst(3, 4); push_burst(0, 4);
    bus.req = 4'b1111;
    run_until(base + 20, 40, used);
    check_eq("t1_cycles", 32'(used), 32'd25);
    bus.req = 4'b0000;

    // Requester 2 withdraws after two words, then is re-granted.
    base = n_writes;
    push_burst(2, 2);
    bus.req = 4'b0100;
    run_until(base + 2, 10, used);
    check_eq("t2_cycles", 32'(used), 32'd3);
    bus.req = 4'b0000;
    tick();
    check_eq("t2_withdraw_busy", 32'(s_busy), 32'd1);
    check_eq("t2_withdraw_vw", 32'(s_vw), 32'd0);
    tick();
    check_eq("t2_idle_busy", 32'(s_busy), 32'd0);
    check_eq("t2_gid_hold", 32'(s_gid), 32'd2);
    base = n_writes;
    push_burst(2, 4);
    bus.req = 4'b0100;
    run_until(base + 4, 10, used);
    check_eq("t2_regrant_cycles", 32'(used), 32'd5);
    bus.req = 4'b0000;

    // Owner 1 stalled by f_flag mid-burst; burst still totals four words.
    base = n_writes;
    push_burst(1, 4);
    bus.req = 4'b0010;
    run_until(base + 2, 10, used);
    bus.f_flag = 1'b1;
    repeat (5) begin
      tick();
      check_eq("t3_stall_vw", 32'(s_vw), 32'd0);
      check_eq("t3_stall_busy", 32'(s_busy), 32'd1);
      check_eq("t3_stall_gid", 32'(s_gid), 32'd1);
    end
    bus.f_flag = 1'b0;
    run_until(base + 4, 10, used);
    check_eq("t3_resume_cycles", 32'(used), 32'd2);
    bus.req = 4'b0000;
    tick();
    check_eq("t3_done_busy", 32'(s_busy), 32'd0);

    // Park last_owner on 3, hold off with f_flag in IDLE, then check the wrap to 0.
    base = n_writes;
    push_burst(3, 4);
    bus.req = 4'b1000;
    run_until(base + 4, 10, used);
    bus.req    = 4'b1001;
    bus.f_flag = 1'b1;
    repeat (3) begin
      tick();
      check_eq("t4_full_idle_busy", 32'(s_busy), 32'd0);
    end
    bus.f_flag = 1'b0;
    base = n_writes;
    push_burst(0, 4); push_burst(3, 4);
    run_until(base + 8, 20, used);
    check_eq("t4_wrap_cycles", 32'(used), 32'd10);
    bus.req = 4'b0000;

    // Reset at beat 2 of a burst owned by 1; afterwards requester 0 wins.
    base = n_writes;
    push_burst(1, 2);
    bus.req = 4'b0010;
    run_until(base + 2, 10, used);
    #2;
    n_rst = 1'b0;
    #1;
    check_eq("t5_rst_ack", 32'(bus.ack), 32'd0);
    check_eq("t5_rst_vw", 32'(bus.valid_write), 32'd0);
    check_eq("t5_rst_busy", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
    bus.req = 4'b0011;
    n_rst   = 1'b1;
    base = n_writes;
    push_burst(0, 4);
    run_until(base + 4, 10, used);
    check_eq("t5_after_rst_cycles", 32'(used), 32'd5);
    bus.req = 4'b0000;

    // almost_full_flag in IDLE: throttles only when the feature is built in.
    base = n_writes;
    push_burst(2, 4);
    bus.almost_full_flag = 1'b1;
    bus.req              = 4'b0100;
    tick();
    check_eq("t6_arb_busy", 32'(s_busy), 32'd0);
    tick();
`ifdef FIFO_ARB_AF_THROTTLE_EN
    check_eq("t6_af_busy", 32'(s_busy), 32'd0);
    check_eq("t6_af_vw", 32'(s_vw), 32'd0);
`else
    check_eq("t6_af_busy", 32'(s_busy), 32'd1);
    check_eq("t6_af_vw", 32'(s_vw), 32'd1);
`endif
    bus.almost_full_flag = 1'b0;
    run_until(base + 4, 10, used);
    bus.req = 4'b0000;
    tick();
    tick();
    check_eq("sb_leftover", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
